// File: rtl/b01_pkg.sv
// Shared constants and types for the b01 output collector.
package b01_pkg;

    // Default word width and overflow-counter width.
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 8;

    // Output holding-register state.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/b01_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module b01_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Count register; never wraps past the all-ones value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/b01_out_collector.sv
// Packs the b01 comparator's serial outp stream into WIDTH-bit words, tags
// each word with any overflw seen during it, and offers the word through a
// one-entry valid/ready holding register. Counts overflow events and flags
// words lost under backpressure.
module b01_out_collector
    import b01_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             outp,
    input  logic             overflw,
    output logic [WIDTH-1:0] word_data,
    output logic             word_ovf,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CNT_W-1:0] ovf_total,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int unsigned BCW = $clog2(WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    // Collector state
    logic [WIDTH-1:0] shift_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic             acc_ovf_q;

    // Output holding register state
    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic             dovf_q;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] new_word;
    logic             new_ovf;
    logic             complete;
    logic             load;
    logic             drop;

    // Current word with this cycle's bit merged in, used both for the
    // collector update and as the completed word.
    always_comb begin
        new_word            = shift_q;
        new_word[bit_cnt_q] = outp;
    end

    assign new_ovf  = acc_ovf_q | overflw;
    assign complete = en && (bit_cnt_q == LAST_BIT);

    // Serial collector: only qualified edges advance it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            acc_ovf_q <= 1'b0;
        end else if (en) begin
            shift_q <= new_word;
            if (complete) begin
                bit_cnt_q <= '0;
                acc_ovf_q <= 1'b0;
            end else begin
                bit_cnt_q <= bit_cnt_q + BCW'(1);
                acc_ovf_q <= new_ovf;
            end
        end
    end

    // Holding-register next state: load, drain, or drop on collision.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        drop      = 1'b0;
        unique case (state_q)
            OUT_EMPTY: begin
                if (complete) begin
                    load    = 1'b1;
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (word_ready) begin
                    // Simultaneous drain and completion keeps valid high.
                    if (complete) begin
                        load = 1'b1;
                    end else begin
                        state_d = OUT_EMPTY;
                    end
                end else if (complete) begin
                    drop = 1'b1;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase

        // A drop in the same cycle as a clear must still be reported.
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // Holding register, FSM state and sticky overrun flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= OUT_EMPTY;
            data_q    <= '0;
            dovf_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
            if (load) begin
                data_q <= new_word;
                dovf_q <= new_ovf;
            end
        end
    end

    b01_sat_counter #(
        .W (CNT_W)
    ) u_ovf_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (en & overflw),
        .count (ovf_total)
    );

    assign word_data  = data_q;
    assign word_ovf   = dovf_q;
    assign word_valid = (state_q == OUT_FULL);
    assign overrun    = overrun_q;

endmodule
